// File: rtl/rf_wb_sched.sv
// +----------------------------------------------------------------------------+
// | rf_wb_sched: register-file write-port scheduler (pipeline vs long-latency) |
// | with a 32-entry pending-write scoreboard driving the decode hazard.        |
// | Optional anti-starvation FORCE state: define RF_WB_STARVE_EN.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rf_wb_sched #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_wa,
  input  logic [31:0] pipe_wd,
  output logic        pipe_stall,
  input  logic        ll_valid,
  output logic        ll_ready,
  input  logic [4:0]  ll_wa,
  input  logic [31:0] ll_wd,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  output logic        hazard,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] busy
);

  // Reject configurations the starvation counter cannot represent.
  if (STARVE_MAX < 1 || STARVE_MAX > 15 || CNT_W < 1 ||
      STARVE_MAX >= (1 << CNT_W)) begin : g_bad_param
    $error("rf_wb_sched: STARVE_MAX must be 1..15 and fit in CNT_W bits");
  end

  logic        w_pipe_gnt;
  logic        w_ll_gnt;
  logic        w_stall;
  logic [31:0] r_busy;
  logic [31:0] w_busy_nxt;
  logic [31:0] w_set;
  logic [31:0] w_clr;

`ifdef RF_WB_STARVE_EN
  typedef enum logic [0:0] {
    ST_NORM  = 1'b0,
    ST_FORCE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] C_FORCE_AT   = CNT_W'(STARVE_MAX - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_NORM;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_pipe_gnt  = 1'b0;
    w_ll_gnt    = 1'b0;
    w_stall     = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_NORM: begin
        if (pipe_we) begin
          w_pipe_gnt = 1'b1;
        end else if (ll_valid) begin
          w_ll_gnt = 1'b1;
        end
        if (ll_valid && !w_ll_gnt) begin
          if (r_cnt != C_STARVE_MAX) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
          if (r_cnt == C_FORCE_AT) begin
            w_state_nxt = ST_FORCE;
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      ST_FORCE: begin
        // The pipe is held even if the ll result vanished, so no pipe write is lost.
        w_ll_gnt    = ll_valid;
        w_stall     = pipe_we;
        w_state_nxt = ST_NORM;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_NORM;
        w_cnt_nxt   = '0;
      end
    endcase
    if (rst) begin
      w_pipe_gnt = 1'b0;
      w_ll_gnt   = 1'b0;
      w_stall    = 1'b0;
    end
  end
`else
  always_comb begin
    w_pipe_gnt = pipe_we & ~rst;
    w_ll_gnt   = ll_valid & ~pipe_we & ~rst;
    w_stall    = 1'b0;
  end
`endif

  always_comb begin
    rf_wa      = w_ll_gnt ? ll_wa : pipe_wa;
    rf_wd      = w_ll_gnt ? ll_wd : pipe_wd;
    rf_we      = (w_pipe_gnt | w_ll_gnt) & (rf_wa != 5'd0);
    ll_ready   = w_ll_gnt;
    pipe_stall = w_stall;
  end

  // A new issue to the register being returned wins: the older result is stale.
  always_comb begin
    w_set      = (iss_valid && iss_rd != 5'd0) ? (32'd1 << iss_rd) : 32'd0;
    w_clr      = (w_ll_gnt && ll_wa != 5'd0) ? (32'd1 << ll_wa) : 32'd0;
    w_busy_nxt = (r_busy & ~w_clr) | w_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= {w_busy_nxt[31:1], 1'b0};
    end
  end

  // Hazard looks only at registered state; a same-cycle grant is not bypassed.
  always_comb begin
    hazard = ~rst & (((dec_rs1 != 5'd0) & r_busy[dec_rs1]) |
                     ((dec_rs2 != 5'd0) & r_busy[dec_rs2]) |
                     ((dec_rd  != 5'd0) & r_busy[dec_rd]));
    busy   = r_busy;
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_sched.sv
// +----------------------------------------------------------------------------+
// | tb_rf_wb_sched: scoreboard bench for rf_wb_sched with a register-file model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rf_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic        pipe_stall;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_wa;
  logic [31:0] ll_wd;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        hazard;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] busy;

  always #5 clk = ~clk;

  rf_wb_sched #(.STARVE_MAX(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd), .pipe_stall(pipe_stall),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_wa(ll_wa), .ll_wd(ll_wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .hazard(hazard),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .busy(busy)
  );

  // Register-file model fed by the scheduler's write port
  logic [31:0] regs [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (rf_we) begin
      regs[rf_wa] <= rf_wd;
    end
  end

  localparam logic [7:0] M_WE = 8'h01, M_WA = 8'h02, M_WD = 8'h04, M_RDY = 8'h08;
  localparam logic [7:0] M_STL = 8'h10, M_HZ = 8'h20, M_BSY = 8'h40, M_RF = 8'h80;
  localparam logic [7:0] M_OUT = 8'h7F;

  typedef struct packed {
    logic [7:0]  m;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rdy;
    logic        stl;
    logic        hz;
    logic [31:0] bsy;
    logic [4:0]  ra;
    logic [31:0] rv;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    checks = 0;
  int    passed = 0;
  exp_t  me;
  string mn;

  task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s.%s actual=%h required=%h", n, f, act, exp);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      mn = nq.pop_front();
      if (me.m[0]) cmp(mn, "rf_we",      32'(rf_we),      32'(me.we));
      if (me.m[1]) cmp(mn, "rf_wa",      32'(rf_wa),      32'(me.wa));
      if (me.m[2]) cmp(mn, "rf_wd",      rf_wd,           me.wd);
      if (me.m[3]) cmp(mn, "ll_ready",   32'(ll_ready),   32'(me.rdy));
      if (me.m[4]) cmp(mn, "pipe_stall", 32'(pipe_stall), 32'(me.stl));
      if (me.m[5]) cmp(mn, "hazard",     32'(hazard),     32'(me.hz));
      if (me.m[6]) cmp(mn, "busy",       busy,            me.bsy);
      if (me.m[7]) cmp(mn, "rf_read",    regs[me.ra],     me.rv);
    end
  end

  task automatic idle();
    pipe_we = 0; pipe_wa = 0; pipe_wd = 0;
    ll_valid = 0; ll_wa = 0; ll_wd = 0;
    iss_valid = 0; iss_rd = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
  endtask

  task automatic chk(input string n, input logic [7:0] m, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic rdy, input logic stl, input logic hz,
                     input logic [31:0] bsy, input logic [4:0] ra = 5'd0, input logic [31:0] rv = 32'd0);
    exp_t e;
    e.m = m; e.we = we; e.wa = wa; e.wd = wd; e.rdy = rdy; e.stl = stl;
    e.hz = hz; e.bsy = bsy; e.ra = ra; e.rv = rv;
    q.push_back(e);
    nq.push_back(n);
    @(posedge clk);
    #1;
  endtask

  logic        starve;
  logic        force_cyc;
  logic [31:0] b_late;

  initial begin
`ifdef RF_WB_STARVE_EN
    starve = 1'b1;
`else
    starve = 1'b0;
`endif
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Outputs forced while reset is held
    pipe_we = 1; pipe_wa = 3; pipe_wd = 32'h1; ll_valid = 1; ll_wa = 4; ll_wd = 32'h2; dec_rs1 = 1;
    chk("rst_out", M_WE | M_RDY | M_STL | M_HZ | M_BSY, 0, 0, 0, 0, 0, 0, 32'h0);

    rst = 1'b0;
    idle(); iss_valid = 1; iss_rd = 5;
    chk("idle", M_WE | M_RDY | M_STL | M_HZ | M_BSY, 0, 0, 0, 0, 0, 0, 32'h0);
    idle(); dec_rs1 = 5;
    chk("hz_rs1", M_WE | M_HZ | M_BSY, 0, 0, 0, 0, 0, 1, 32'h20);
    idle(); dec_rs2 = 5;
    chk("hz_rs2", M_HZ, 0, 0, 0, 0, 0, 1, 32'h20);
    idle(); dec_rd = 5;
    chk("hz_rd", M_HZ, 0, 0, 0, 0, 0, 1, 32'h20);
    idle();
    chk("hz_x0", M_HZ | M_BSY, 0, 0, 0, 0, 0, 0, 32'h20);

    // Long-latency write with an idle pipe; hazard not bypassed this cycle
    idle(); ll_valid = 1; ll_wa = 5; ll_wd = 32'hDEADBEEF; dec_rs1 = 5;
    chk("ll_gnt", M_OUT, 1, 5, 32'hDEADBEEF, 1, 0, 1, 32'h20);
    idle(); dec_rs1 = 5;
    chk("ll_done", M_HZ | M_BSY | M_RF, 0, 0, 0, 0, 0, 0, 32'h0, 5'd5, 32'hDEADBEEF);

    idle(); pipe_we = 1; pipe_wa = 3; pipe_wd = 32'h11111111; iss_valid = 1; iss_rd = 9;
    chk("pipe_gnt", M_OUT, 1, 3, 32'h11111111, 0, 0, 0, 32'h0);
    idle(); pipe_we = 1; pipe_wa = 0; pipe_wd = 32'h5;
    chk("pipe_x0", M_WE | M_RDY | M_STL | M_BSY | M_RF, 0, 0, 0, 0, 0, 0, 32'h200, 5'd3, 32'h11111111);

    // Continuous pipeline traffic against a waiting long-latency result
    for (int i = 1; i <= 6; i++) begin
      idle(); pipe_we = 1; pipe_wa = 3; pipe_wd = 32'hA0 + 32'(i);
      ll_valid = 1; ll_wa = 9; ll_wd = 32'hCAFE0009;
      force_cyc = starve && (i == 5);
      if (force_cyc)
        chk("force", M_OUT, 1, 9, 32'hCAFE0009, 1, 1, 0, 32'h200);
      else
        chk("starve", M_OUT, 1, 3, 32'hA0 + 32'(i), 0, 0, 0, (starve && i == 6) ? 32'h0 : 32'h200);
    end
    b_late = starve ? 32'h0 : 32'h200;
    idle(); ll_valid = 1; ll_wa = 9; ll_wd = 32'hCAFE0009;
    chk("ll_late", M_OUT, 1, 9, 32'hCAFE0009, 1, 0, 0, b_late);
    idle();
    chk("ll_late_done", M_BSY | M_RF, 0, 0, 0, 0, 0, 0, 32'h0, 5'd9, 32'hCAFE0009);

    // Set and clear of the same register in one cycle: set wins
    idle(); iss_valid = 1; iss_rd = 7;
    chk("iss7", M_BSY, 0, 0, 0, 0, 0, 0, 32'h0);
    idle(); iss_valid = 1; iss_rd = 7; ll_valid = 1; ll_wa = 7; ll_wd = 32'h77;
    chk("setclr", M_OUT, 1, 7, 32'h77, 1, 0, 0, 32'h80);
    idle(); dec_rs1 = 7; iss_valid = 1; iss_rd = 8; ll_valid = 1; ll_wa = 7; ll_wd = 32'h78;
    chk("set_wins", M_HZ | M_BSY | M_RDY | M_RF, 0, 0, 0, 1, 0, 1, 32'h80, 5'd7, 32'h77);
    idle(); ll_valid = 1; ll_wa = 8; ll_wd = 32'h8;
    chk("clr7_set8", M_BSY | M_RDY | M_WE, 1, 0, 0, 1, 0, 0, 32'h100);

    // Long-latency write to x0 completes the handshake without a file write
    idle(); ll_valid = 1; ll_wa = 0; ll_wd = 32'h1; iss_valid = 1; iss_rd = 0;
    chk("ll_x0", M_WE | M_RDY | M_STL | M_BSY, 0, 0, 0, 1, 0, 0, 32'h0);
    idle();
    chk("x0_read", M_BSY | M_RF, 0, 0, 0, 0, 0, 0, 32'h0, 5'd0, 32'h0);

    // Fill the scoreboard, build up starvation, then reset mid-transaction
    for (int i = 1; i < 32; i++) begin
      idle(); iss_valid = 1; iss_rd = 5'(i);
      @(posedge clk); #1;
    end
    for (int j = 1; j <= 3; j++) begin
      idle(); pipe_we = 1; pipe_wa = 3; pipe_wd = 32'(j); ll_valid = 1; ll_wa = 4; ll_wd = 32'h44; dec_rs1 = 1;
      chk("pre_rst", M_RDY | M_HZ | M_BSY, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFE);
    end
    rst = 1'b1;
    chk("rst_mid", M_WE | M_RDY | M_STL | M_HZ | M_BSY, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFE);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      force_cyc = starve && (i == 5);
      if (force_cyc)
        chk("post_rst_force", M_WE | M_WA | M_RDY | M_STL | M_HZ | M_BSY, 1, 4, 0, 1, 1, 0, 32'h0);
      else
        chk("post_rst", M_WE | M_WA | M_RDY | M_STL | M_HZ | M_BSY, 1, 3, 0, 0, 0, 0, 32'h0);
    end
    idle();

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
